// File: rtl/multi_fifo_push_sched_if.sv
// rtl/multi_fifo_push_sched_if.sv - requester and FIFO push-side bundle for multi_fifo_push_sched
interface multi_fifo_push_sched_if #(
  parameter type T     = logic [7:0],
  parameter int  R     = 4,
  parameter int  M     = 4,
  parameter int  DEPTH = 16,
  parameter int  CW    = $clog2(DEPTH) + 1,
  parameter int  NW    = $clog2(M + 1)
);
  logic [R-1:0]         req_valid;
  logic [R-1:0][NW-1:0] req_cnt;
  T                     req_data [R][M];
  logic [R-1:0]         req_ready;
  logic [M-1:0]         fifo_push;
  T                     fifo_datain [M];
  logic [CW-1:0]        fifo_pop_count;
  logic                 clear;
  logic [CW-1:0]        credits;

  modport master (
    input  req_valid, req_cnt, req_data, fifo_pop_count, clear,
    output req_ready, fifo_push, fifo_datain, credits
  );

  modport slave (
    output req_valid, req_cnt, req_data, fifo_pop_count, clear,
    input  req_ready, fifo_push, fifo_datain, credits
  );
endinterface

// File: rtl/multi_fifo_push_sched.sv
// rtl/multi_fifo_push_sched.sv - round-robin batch scheduler onto a shared multi-lane FIFO push port
module multi_fifo_push_sched #(
  parameter type T     = logic [7:0],
  parameter int  R     = 4,
  parameter int  M     = 4,
  parameter int  DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  multi_fifo_push_sched_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (R > 1) ? $clog2(R) : 1;

  logic [CW-1:0] credits_q, credits_d;
  logic [RW-1:0] rr_ptr_q, rr_ptr_d;
  logic [M-1:0]  push_q, push_d;
  T              datain_q [M];
  T              datain_d [M];

  logic [R-1:0]  grant;
  logic [CW-1:0] base [R];
  logic [CW-1:0] lanes_left, cred_left, granted_total;
  logic [RW-1:0] idx, last_idx;
  logic [CW-1:0] cnt_w;
  logic          elig, stopped, any_grant, block;
  logic [CW-1:0] inflight, occupancy;

  assign block = rst_i | bus.clear;

  // Scan from rr_ptr; an eligible batch that does not fit ends the scan so order is preserved.
  always_comb begin
    grant      = '0;
    lanes_left = CW'(M);
    cred_left  = credits_q;
    stopped    = 1'b0;
    any_grant  = 1'b0;
    last_idx   = rr_ptr_q;
    idx        = '0;
    cnt_w      = '0;
    elig       = 1'b0;
    for (int r = 0; r < R; r++) base[r] = '0;
    for (int s = 0; s < R; s++) begin
      idx   = RW'((int'(rr_ptr_q) + s) % R);
      cnt_w = CW'(bus.req_cnt[idx]);
      elig  = bus.req_valid[idx] && (cnt_w != '0) && (cnt_w <= CW'(M));
      if (!block && !stopped && elig) begin
        if ((cnt_w <= lanes_left) && (cnt_w <= cred_left)) begin
          grant[idx] = 1'b1;
          base[idx]  = CW'(M) - lanes_left;
          lanes_left = lanes_left - cnt_w;
          cred_left  = cred_left - cnt_w;
          last_idx   = idx;
          any_grant  = 1'b1;
        end else begin
          stopped = 1'b1;
        end
      end
    end
    granted_total = CW'(M) - lanes_left;
  end

  always_comb begin
    for (int l = 0; l < M; l++) begin
      push_d[l]   = (CW'(l) < granted_total);
      datain_d[l] = '0;
      for (int r = 0; r < R; r++) begin
        for (int k = 0; k < M; k++) begin
          if (grant[r] && (CW'(k) < CW'(bus.req_cnt[r])) && (base[r] + CW'(k) == CW'(l)))
            datain_d[l] = bus.req_data[r][k];
        end
      end
    end
  end

  always_comb begin
    credits_d = credits_q - granted_total + bus.fifo_pop_count;
    rr_ptr_d  = rr_ptr_q;
    if (any_grant)
      rr_ptr_d = (last_idx == RW'(R - 1)) ? '0 : last_idx + RW'(1);
  end

  // Entries already in the FIFO exclude both free credits and the push still in flight.
  assign inflight  = CW'($countones(push_q));
  assign occupancy = CW'(DEPTH) - credits_q - inflight;

  always_ff @(posedge clk_i) begin
    if (block) begin
      credits_q <= CW'(DEPTH);
      rr_ptr_q  <= '0;
      push_q    <= '0;
      for (int l = 0; l < M; l++) datain_q[l] <= '0;
    end else begin
      assert (bus.fifo_pop_count <= occupancy);
      assert (credits_d <= CW'(DEPTH));
      credits_q <= credits_d;
      rr_ptr_q  <= rr_ptr_d;
      push_q    <= push_d;
      for (int l = 0; l < M; l++) datain_q[l] <= datain_d[l];
    end
  end

  assign bus.req_ready   = grant;
  assign bus.fifo_push   = push_q;
  assign bus.fifo_datain = datain_q;
  assign bus.credits     = credits_q;
endmodule

// File: tb/tb_multi_fifo_push_sched.sv
// tb/tb_multi_fifo_push_sched.sv - directed self-checking bench for multi_fifo_push_sched
module tb_multi_fifo_push_sched;
  localparam int R = 4;
  localparam int M = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_d [M];

  always #5 clk = ~clk;

  multi_fifo_push_sched_if #(.T(logic [7:0]), .R(R), .M(M), .DEPTH(DEPTH)) bus ();

  multi_fifo_push_sched #(.T(logic [7:0]), .R(R), .M(M), .DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid      = '0;
    bus.req_cnt        = '0;
    bus.fifo_pop_count = '0;
    bus.clear          = 1'b0;
    for (int r = 0; r < R; r++)
      for (int k = 0; k < M; k++) bus.req_data[r][k] = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    for (int r = 0; r < R; r++) bus.req_cnt[r] = 3'd1;
    bus.req_data[0][0] = 8'hA1;
    bus.req_data[1][0] = 8'hB2;
    bus.req_data[2][0] = 8'hC3;
    bus.req_data[3][0] = 8'hD4;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready0: got %b expected 0000", bus.req_ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
      checks++;
      if (bus.credits !== 5'd16) begin errors++; $display("FAIL reset_credits: got %0d expected 16", bus.credits); end
      checks++;
      if (bus.fifo_push !== 4'b0000) begin errors++; $display("FAIL reset_push: got %b expected 0000", bus.fifo_push); end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1111) begin errors++; $display("FAIL reset_release_ready: got %b expected 1111", bus.req_ready); end
  endtask

  task automatic test_packing();
    tick();
    bus.req_valid = '0;
    checks++;
    if (bus.fifo_push !== 4'b1111) begin errors++; $display("FAIL pack_push: got %b expected 1111", bus.fifo_push); end
    exp_d[0] = 8'hA1; exp_d[1] = 8'hB2; exp_d[2] = 8'hC3; exp_d[3] = 8'hD4;
    for (int l = 0; l < M; l++) begin
      checks++;
      if (bus.fifo_datain[l] !== exp_d[l]) begin errors++; $display("FAIL pack_data lane %0d: got %h expected %h", l, bus.fifo_datain[l], exp_d[l]); end
    end
    checks++;
    if (bus.credits !== 5'd12) begin errors++; $display("FAIL pack_credits: got %0d expected 12", bus.credits); end
    tick();
    checks++;
    if (bus.fifo_push !== 4'b0000) begin errors++; $display("FAIL pack_idle_push: got %b expected 0000", bus.fifo_push); end
    for (int l = 0; l < M; l++) begin
      checks++;
      if (bus.fifo_datain[l] !== 8'h00) begin errors++; $display("FAIL pack_idle_data lane %0d: got %h expected 00", l, bus.fifo_datain[l]); end
    end
    checks++;
    if (bus.credits !== 5'd12) begin errors++; $display("FAIL pack_idle_credits: got %0d expected 12", bus.credits); end
  endtask

  task automatic test_lane_block();
    do_reset();
    bus.req_valid = 4'b0011;
    bus.req_cnt[0] = 3'd3;
    bus.req_cnt[1] = 3'd2;
    bus.req_data[0][0] = 8'h11; bus.req_data[0][1] = 8'h12; bus.req_data[0][2] = 8'h13;
    bus.req_data[1][0] = 8'h21; bus.req_data[1][1] = 8'h22;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL block_ready1: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_data[0][0] = 8'h14; bus.req_data[0][1] = 8'h15; bus.req_data[0][2] = 8'h16;
    checks++;
    if (bus.fifo_push !== 4'b0111) begin errors++; $display("FAIL block_push1: got %b expected 0111", bus.fifo_push); end
    exp_d[0] = 8'h11; exp_d[1] = 8'h12; exp_d[2] = 8'h13; exp_d[3] = 8'h00;
    for (int l = 0; l < M; l++) begin
      checks++;
      if (bus.fifo_datain[l] !== exp_d[l]) begin errors++; $display("FAIL block_data1 lane %0d: got %h expected %h", l, bus.fifo_datain[l], exp_d[l]); end
    end
    checks++;
    if (bus.credits !== 5'd13) begin errors++; $display("FAIL block_credits1: got %0d expected 13", bus.credits); end
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL block_ready2: got %b expected 0010", bus.req_ready); end
    tick();
    idle_inputs();
    checks++;
    if (bus.fifo_push !== 4'b0011) begin errors++; $display("FAIL block_push2: got %b expected 0011", bus.fifo_push); end
    exp_d[0] = 8'h21; exp_d[1] = 8'h22; exp_d[2] = 8'h00; exp_d[3] = 8'h00;
    for (int l = 0; l < M; l++) begin
      checks++;
      if (bus.fifo_datain[l] !== exp_d[l]) begin errors++; $display("FAIL block_data2 lane %0d: got %h expected %h", l, bus.fifo_datain[l], exp_d[l]); end
    end
    checks++;
    if (bus.credits !== 5'd11) begin errors++; $display("FAIL block_credits2: got %0d expected 11", bus.credits); end
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_cnt[0] = 3'd4;
    for (int k = 0; k < M; k++) bus.req_data[0][k] = 8'h41 + 8'(k);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL credit_grant%0d: got %b expected 0001", i, bus.req_ready); end
      tick();
      checks++;
      if (bus.credits !== 5'(12 - 4 * i)) begin errors++; $display("FAIL credit_count%0d: got %0d expected %0d", i, bus.credits, 12 - 4 * i); end
    end
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL credit_empty_ready: got %b expected 0000", bus.req_ready); end
    bus.fifo_pop_count = 5'd2;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL credit_pop_ready: got %b expected 0000", bus.req_ready); end
    tick();
    bus.fifo_pop_count = 5'd0;
    checks++;
    if (bus.credits !== 5'd2) begin errors++; $display("FAIL credit_after_pop: got %0d expected 2", bus.credits); end
    checks++;
    if (bus.fifo_push !== 4'b0000) begin errors++; $display("FAIL credit_pop_push: got %b expected 0000", bus.fifo_push); end
    bus.req_cnt[0] = 3'd2;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL credit_regrant_ready: got %b expected 0001", bus.req_ready); end
    tick();
    idle_inputs();
    checks++;
    if (bus.credits !== 5'd0) begin errors++; $display("FAIL credit_regrant_credits: got %0d expected 0", bus.credits); end
    checks++;
    if (bus.fifo_push !== 4'b0011) begin errors++; $display("FAIL credit_regrant_push: got %b expected 0011", bus.fifo_push); end
  endtask

  task automatic test_skip_ineligible();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_cnt[0] = 3'd1;
    bus.req_data[0][0] = 8'h01;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL skip_setup_ready: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b1110;
    bus.req_cnt[0] = 3'd0;
    bus.req_cnt[1] = 3'd0;
    bus.req_cnt[2] = 3'd5;
    bus.req_cnt[3] = 3'd2;
    bus.req_data[3][0] = 8'h31; bus.req_data[3][1] = 8'h32;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL skip_ready: got %b expected 1000", bus.req_ready); end
    tick();
    checks++;
    if (bus.fifo_push !== 4'b0011) begin errors++; $display("FAIL skip_push: got %b expected 0011", bus.fifo_push); end
    exp_d[0] = 8'h31; exp_d[1] = 8'h32; exp_d[2] = 8'h00; exp_d[3] = 8'h00;
    for (int l = 0; l < M; l++) begin
      checks++;
      if (bus.fifo_datain[l] !== exp_d[l]) begin errors++; $display("FAIL skip_data lane %0d: got %h expected %h", l, bus.fifo_datain[l], exp_d[l]); end
    end
    checks++;
    if (bus.credits !== 5'd13) begin errors++; $display("FAIL skip_credits: got %0d expected 13", bus.credits); end
    bus.req_valid = 4'b1001;
    bus.req_cnt[0] = 3'd1; bus.req_cnt[3] = 3'd1;
    bus.req_data[0][0] = 8'h51; bus.req_data[3][0] = 8'h52;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1001) begin errors++; $display("FAIL skip_wrap_ready: got %b expected 1001", bus.req_ready); end
    tick();
    idle_inputs();
    exp_d[0] = 8'h51; exp_d[1] = 8'h52; exp_d[2] = 8'h00; exp_d[3] = 8'h00;
    for (int l = 0; l < M; l++) begin
      checks++;
      if (bus.fifo_datain[l] !== exp_d[l]) begin errors++; $display("FAIL skip_wrap_data lane %0d: got %h expected %h", l, bus.fifo_datain[l], exp_d[l]); end
    end
  endtask

  task automatic test_clear();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_cnt[0] = 3'd4;
    tick();
    tick();
    bus.req_cnt[0] = 3'd3;
    tick();
    checks++;
    if (bus.credits !== 5'd5) begin errors++; $display("FAIL clear_setup_credits: got %0d expected 5", bus.credits); end
    bus.req_cnt[0] = 3'd1;
    bus.clear = 1'b1;
    bus.fifo_pop_count = 5'd3;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL clear_ready: got %b expected 0000", bus.req_ready); end
    tick();
    bus.clear = 1'b0;
    bus.fifo_pop_count = 5'd0;
    checks++;
    if (bus.credits !== 5'd16) begin errors++; $display("FAIL clear_credits: got %0d expected 16", bus.credits); end
    checks++;
    if (bus.fifo_push !== 4'b0000) begin errors++; $display("FAIL clear_push: got %b expected 0000", bus.fifo_push); end
    bus.req_valid = 4'b0011;
    bus.req_cnt[0] = 3'd4; bus.req_cnt[1] = 3'd4;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL clear_rr_ready: got %b expected 0001", bus.req_ready); end
    tick();
    idle_inputs();
    checks++;
    if (bus.credits !== 5'd12) begin errors++; $display("FAIL clear_rr_credits: got %0d expected 12", bus.credits); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_packing();
    test_lane_block();
    test_credit_exhaust();
    test_skip_ineligible();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
